// File: rtl/n64_response_tx_if.sv
// Byte handshake between the upstream command logic and the joybus response transmitter.
// A byte transfers on a rising edge where tx_valid && tx_ready; data and last are held stable while valid waits.
interface n64_response_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
   modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/n64_response_tx.sv
// Joybus response serializer: one holding byte plus a shift byte, MSB-first
// quarter-bit encoding, closed by a 2-quarter stop bit.
module n64_response_tx #(
   parameter int unsigned QCLKS = 50
) (
   input  logic                 sample_clk,
   input  logic                 reset,
   n64_response_tx_if.slave     tx,
   output logic                 data_out,
   output logic                 busy,
   output logic                 done,
   output logic                 underrun,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {IDLE, BIT_LOW, BIT_HIGH, STOP_LOW} state_t;

   localparam logic [7:0] QLAST = 8'(QCLKS - 1);

   state_t     state;
   logic [7:0] buf_data;
   logic       buf_last;
   logic       buf_full;
   logic [7:0] shift_data;
   logic       shift_last;
   logic       stop_done;
   logic [7:0] qcnt;
   logic [1:0] qidx;
   logic [2:0] bit_idx;

   logic       q_end;
   logic [1:0] low_qlast;
   logic [1:0] high_qlast;
   logic       ready_int;

   // The bit being sent always sits in shift_data[7]; it sets how many quarters each phase lasts.
   assign q_end      = (qcnt == QLAST);
   assign low_qlast  = shift_data[7] ? 2'd0 : 2'd2;
   assign high_qlast = shift_data[7] ? 2'd2 : 2'd0;
   assign ready_int  = !buf_full && (state != STOP_LOW);

   assign tx.tx_ready = ready_int;
   assign busy        = (state != IDLE);
   assign dbg_state   = state;

   always_ff @(posedge sample_clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         buf_data   <= 8'd0;
         buf_last   <= 1'b0;
         buf_full   <= 1'b0;
         shift_data <= 8'd0;
         shift_last <= 1'b0;
         stop_done  <= 1'b0;
         qcnt       <= 8'd0;
         qidx       <= 2'd0;
         bit_idx    <= 3'd0;
         data_out   <= 1'b1;
         done       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         done     <= 1'b0;
         underrun <= 1'b0;

         // Outside IDLE an accepted byte parks in the holding buffer; the case below may override the flag.
         if (tx.tx_valid && ready_int && state != IDLE) begin
            buf_data <= tx.tx_data;
            buf_last <= tx.tx_last;
            buf_full <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (tx.tx_valid) begin
                  shift_data <= tx.tx_data;
                  shift_last <= tx.tx_last;
                  bit_idx    <= 3'd7;
                  qcnt       <= 8'd0;
                  qidx       <= 2'd0;
                  data_out   <= 1'b0;
                  state      <= BIT_LOW;
               end
            end

            BIT_LOW: begin
               if (q_end) begin
                  qcnt <= 8'd0;
                  if (qidx == low_qlast) begin
                     qidx     <= 2'd0;
                     data_out <= 1'b1;
                     state    <= BIT_HIGH;
                  end else begin
                     qidx <= qidx + 2'd1;
                  end
               end else begin
                  qcnt <= qcnt + 8'd1;
               end
            end

            BIT_HIGH: begin
               if (q_end) begin
                  qcnt <= 8'd0;
                  if (qidx == high_qlast) begin
                     qidx     <= 2'd0;
                     data_out <= 1'b0;
                     if (bit_idx != 3'd0) begin
                        shift_data <= {shift_data[6:0], 1'b0};
                        bit_idx    <= bit_idx - 3'd1;
                        state      <= BIT_LOW;
                     end else if (shift_last) begin
                        buf_full  <= 1'b0;
                        stop_done <= 1'b1;
                        state     <= STOP_LOW;
                     end else if (buf_full) begin
                        shift_data <= buf_data;
                        shift_last <= buf_last;
                        buf_full   <= 1'b0;
                        bit_idx    <= 3'd7;
                        state      <= BIT_LOW;
                     end else begin
                        // Upstream starved us mid-response: close the line without signalling done.
                        underrun  <= 1'b1;
                        buf_full  <= 1'b0;
                        stop_done <= 1'b0;
                        state     <= STOP_LOW;
                     end
                  end else begin
                     qidx <= qidx + 2'd1;
                  end
               end else begin
                  qcnt <= qcnt + 8'd1;
               end
            end

            STOP_LOW: begin
               if (q_end) begin
                  qcnt <= 8'd0;
                  if (qidx == 2'd1) begin
                     qidx     <= 2'd0;
                     data_out <= 1'b1;
                     done     <= stop_done;
                     state    <= IDLE;
                  end else begin
                     qidx <= qidx + 2'd1;
                  end
               end else begin
                  qcnt <= qcnt + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/n64_response_tx.md
N64_RESPONSE_TX -- requirements
Module: n64_response_tx

Interface
REQ-001 Parameter QCLKS, default 50: sample_clk cycles per quarter-bit (1 us at 50 MHz); legal range 2..255.
REQ-002 sample_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
REQ-004 tx_data  input  8  response byte offered by the upstream command logic.
REQ-005 tx_valid  input  1  tx_data/tx_last are valid this cycle.
REQ-006 tx_last  input  1  offered byte is the final byte of the response.
REQ-007 tx_ready  output  1  holding buffer empty; the byte is accepted when tx_valid && tx_ready.
REQ-008 data_out  output  1  joybus line level; 0 = drive low, 1 = released (pulled high).
REQ-009 busy  output  1  a response is in progress (any state other than IDLE).
REQ-010 done  output  1  one-cycle pulse when the stop bit completes.
REQ-011 underrun  output  1  one-cycle pulse when a non-last byte completes with the holding buffer empty.

Function
REQ-012 The block SHALL hold a one-entry holding buffer (byte + last flag) and a shift register (byte + last flag), and SHALL send each byte MSB first.
REQ-013 Bit cell = 4 quarters of QCLKS cycles each: bit 1 = 1 quarter low then 3 quarters high; bit 0 = 3 quarters low then 1 quarter high.
REQ-014 Stop bit = 2 quarters low, then release; data_out SHALL remain 1 in IDLE.
REQ-015 States: IDLE, BIT_LOW, BIT_HIGH, STOP_LOW; no other states.
REQ-016 IDLE -> BIT_LOW on the cycle a byte is accepted; the byte loads directly into the shift register, and data_out goes 0 on the next clock edge (1-cycle latency).
REQ-017 BIT_LOW -> BIT_HIGH after the low quarters of the current bit expire; BIT_HIGH -> BIT_LOW (next bit) after the high quarters expire.
REQ-018 After bit 0 (LSB) BIT_HIGH expires, the next state SHALL be chosen as follows.
- If the shift register's last flag is set: STOP_LOW.
- Else, if the holding buffer is full: load the shift register from the buffer and go to BIT_LOW, with no gap cycle.
- Else: pulse underrun and go to STOP_LOW.
REQ-019 STOP_LOW -> IDLE after 2 quarters; done pulses on the cycle data_out returns to 1.
REQ-020 tx_ready SHALL equal "holding buffer empty" (combinational from registered state).
- Accepting a byte in IDLE bypasses the buffer.
- In all other states an accepted byte fills the buffer.
REQ-021 A byte accepted on the same cycle the buffer drains (REQ-018) SHALL be forbidden by construction: tx_ready is registered-state based, so the buffer is seen full that cycle.
REQ-022 tx_valid SHALL be ignored while tx_ready = 0, and in STOP_LOW.
- In STOP_LOW, tx_ready = 0 and the buffer is cleared on entry.
REQ-023 tx_last on a byte arriving after an underrun is irrelevant; each new response starts from IDLE.
REQ-024 Quarter counter width: 8 bits; bit index: 3 bits; quarter index: 2 bits; all wrap only under explicit reload, never free-run.
REQ-025 Total response length for N bytes SHALL be 32*N*QCLKS + 2*QCLKS cycles of line activity, independent of data values.
REQ-026 done and underrun SHALL never assert in the same cycle.

Reset
REQ-027 Asserting reset at any time, including mid-bit, SHALL immediately set:
- data_out = 1, busy = 0, done = 0, underrun = 0, tx_ready = 1;
- state IDLE, with the buffer, shift register and counters cleared.
REQ-028 After reset deasserts, the first acceptable byte is on the first rising edge with tx_valid = 1; no partial stop bit is emitted.

Verification (QCLKS = 2 unless stated)
REQ-029 Single byte 0xA5, tx_last = 1, in IDLE -> data_out per bit, then stop, then done:
- bits 1,0,1,0,0,1,0,1 as 2-low/6-high and 6-low/2-high runs;
- stop bit = 4 cycles low;
- done pulses on cycle 69 after acceptance; busy high for cycles 1-68.
REQ-030 Back-to-back 0x00, 0xFF (last); second byte offered during the first -> tx_ready drops after the buffer fills.
- First byte: eight 6-low/2-high cells.
- Second byte starts with zero gap: eight 2-low/6-high cells.
- Then stop and done; total active 132 cycles.
REQ-031 Byte 0x80, tx_last = 0, no second byte -> underrun pulses once at the end of bit 0, then a 4-cycle stop low; done does not pulse.
REQ-032 Reset asserted 3 cycles into the low phase of the second bit of 0x3C -> data_out = 1 and tx_ready = 1 within the same cycle (asynchronous).
- A new 0x01 (last) after release transmits correctly from its MSB.
REQ-033 tx_valid held high with buffer full, and during STOP_LOW -> no extra byte captured; the response length exactly matches the accepted bytes.
REQ-034 QCLKS = 50, byte 0x01 (last) -> bit 7 low for exactly 150 cycles and the final bit low for 50 cycles; stop low for 100 cycles.
